// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Brief    : Time-multiplexed 9-tap FIR, one shared MAC step per cycle.
//            Define FIR_MAC_SAT_EN to saturate the scaled output instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
  parameter int NTAPS  = 9,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40,
  parameter int SHIFT  = 4,
  parameter logic signed [COEF_W-1:0] H [NTAPS] = '{
    16'sd90, -16'sd40, -16'sd10, 16'sd10, 16'sd10,
    16'sd10, -16'sd10, -16'sd40, 16'sd90}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic              busy
);

  localparam int PTR_W  = $clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(NTAPS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_MOD = PTR_W'(NTAPS);
  localparam logic [ACC_W-1:0] BIAS    = (ACC_W'(1) << SHIFT) - ACC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          newest_q, newest_d;
  logic [PTR_W-1:0]          tap_idx_q, tap_idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]         y_q, y_d;
  logic [DATA_W-1:0]         hist_q [NTAPS];
  logic                      hist_we;
  logic                      hist_clr;

  logic [PTR_W-1:0]          rd_idx;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   biased;
  logic signed [ACC_W-1:0]   quot;
  logic [DATA_W-1:0]         y_scaled;

  // newest + NTAPS - tap stays below NTAPS, so PTR_W-bit modular math is exact.
  always_comb begin
    if (newest_q >= tap_idx_q) rd_idx = newest_q - tap_idx_q;
    else                       rd_idx = newest_q + PTR_MOD - tap_idx_q;
  end

  assign prod    = H[tap_idx_q] * $signed(hist_q[rd_idx]);
  assign acc_sum = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Bias negative values before the arithmetic shift to truncate toward zero.
  assign biased = acc_sum + (acc_sum[ACC_W-1] ? $signed(BIAS) : '0);
  assign quot   = biased >>> SHIFT;

`ifdef FIR_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX =
    $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] Y_MIN =
    $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  always_comb begin
    y_scaled = quot[DATA_W-1:0];
    if (quot > Y_MAX)      y_scaled = Y_MAX[DATA_W-1:0];
    else if (quot < Y_MIN) y_scaled = Y_MIN[DATA_W-1:0];
  end
`else
  logic unused_quot_hi;
  assign unused_quot_hi = ^quot[ACC_W-1:DATA_W];
  assign y_scaled       = quot[DATA_W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    newest_d  = newest_q;
    tap_idx_d = tap_idx_q;
    acc_d     = acc_q;
    y_d       = y_q;
    hist_we   = 1'b0;
    hist_clr  = 1'b0;
    if (clear) begin
      state_d   = S_IDLE;
      wr_ptr_d  = '0;
      newest_d  = '0;
      tap_idx_d = '0;
      acc_d     = '0;
      hist_clr  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            hist_we   = 1'b1;
            newest_d  = wr_ptr_q;
            wr_ptr_d  = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_ONE;
            acc_d     = '0;
            tap_idx_d = '0;
            state_d   = S_MAC;
          end
        end
        S_MAC: begin
          acc_d     = acc_sum;
          tap_idx_d = tap_idx_q + PTR_ONE;
          if (tap_idx_q == LAST) begin
            tap_idx_d = '0;
            y_d       = y_scaled;
            state_d   = S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      newest_q  <= '0;
      tap_idx_q <= '0;
      acc_q     <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      newest_q  <= newest_d;
      tap_idx_q <= tap_idx_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || hist_clr) begin
      for (int i = 0; i < NTAPS; i++) hist_q[i] <= '0;
    end else if (hist_we) begin
      hist_q[wr_ptr_q] <= x;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign y         = y_q;

endmodule
`default_nettype wire
